// File: rtl/onehot_valid_table_if.sv
// Bundle of the set/clear/flush/lookup controls and the table status outputs.
// The master drives the controls; the slave (the table) drives the status.
interface onehot_valid_table_if #(
  parameter int IDX_W   = 6,
  parameter int ENTRIES = 1 << IDX_W
);
  logic               set_en;
  logic [IDX_W-1:0]   set_idx;
  logic               clr_en;
  logic [IDX_W-1:0]   clr_idx;
  logic               flush;
  logic [IDX_W-1:0]   rd_idx;
  logic [ENTRIES-1:0] rd_onehot;
  logic               rd_valid;
  logic [ENTRIES-1:0] valid_vec;
  logic               free_found;
  logic [IDX_W-1:0]   free_idx;
  logic [IDX_W:0]     count;
  logic               full;

  modport master (
    output set_en, set_idx, clr_en, clr_idx, flush, rd_idx,
    input  rd_onehot, rd_valid, valid_vec, free_found, free_idx, count, full
  );

  modport slave (
    input  set_en, set_idx, clr_en, clr_idx, flush, rd_idx,
    output rd_onehot, rd_valid, valid_vec, free_found, free_idx, count, full
  );
endinterface

// File: rtl/onehot_valid_table.sv
// Per-entry valid bitmap with decoded set/clear/flush, a registered one-hot lookup,
// a lowest-free-entry allocator, an incrementally maintained occupancy count and a full flag.
module onehot_valid_table #(
  parameter int IDX_W   = 6,
  parameter int ENTRIES = 1 << IDX_W
) (
  input  logic                  clk,
  input  logic                  rst,
  onehot_valid_table_if.slave   bus
);
  logic [ENTRIES-1:0] r_valid_vec;
  logic [ENTRIES-1:0] r_rd_onehot;
  logic               r_rd_valid;
  logic [IDX_W:0]     r_count;

  logic [ENTRIES-1:0] w_set_dec;
  logic [ENTRIES-1:0] w_clr_dec;
  logic [ENTRIES-1:0] w_rd_dec;
  logic [ENTRIES-1:0] w_valid_next;
  logic               w_set_rise;
  logic               w_clr_fall;
  logic [IDX_W-1:0]   w_free_idx;

  // Only ENTRIES decode bits exist, so out-of-range indices decode to all-zero.
  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_dec
      assign w_set_dec[gi] = bus.set_en & (bus.set_idx == IDX_W'(gi));
      assign w_clr_dec[gi] = bus.clr_en & (bus.clr_idx == IDX_W'(gi));
      assign w_rd_dec[gi]  = (bus.rd_idx == IDX_W'(gi));
    end
  endgenerate

  assign w_valid_next = (r_valid_vec & ~w_clr_dec) | w_set_dec;
  assign w_set_rise   = |(w_set_dec & ~r_valid_vec);
  // A clear that collides with a set on the same entry loses, so it is not a 1->0 transition.
  assign w_clr_fall   = |(w_clr_dec & r_valid_vec & ~w_set_dec);

  always_comb begin
    w_free_idx = '0;
    for (int k = ENTRIES - 1; k >= 0; k--) begin
      if (!r_valid_vec[k]) w_free_idx = IDX_W'(k);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid_vec <= '0;
      r_count     <= '0;
      r_rd_onehot <= '0;
      r_rd_valid  <= 1'b0;
    end else begin
      r_rd_onehot <= w_rd_dec;
      r_rd_valid  <= |(w_rd_dec & r_valid_vec);
      if (bus.flush) begin
        r_valid_vec <= '0;
        r_count     <= '0;
      end else begin
        r_valid_vec <= w_valid_next;
        r_count     <= r_count + (IDX_W+1)'(w_set_rise) - (IDX_W+1)'(w_clr_fall);
      end
    end
  end

  assign bus.rd_onehot  = r_rd_onehot;
  assign bus.rd_valid   = r_rd_valid;
  assign bus.valid_vec  = r_valid_vec;
  assign bus.free_found = ~&r_valid_vec;
  assign bus.free_idx   = w_free_idx;
  assign bus.count      = r_count;
  assign bus.full       = (r_count == (IDX_W+1)'(ENTRIES));
endmodule
